// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the SLC-3 memory responder.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [15:0] IO_ADDR_DEF  = 16'hFFFF;
  localparam logic [15:0] CNT_ADDR_DEF = 16'hFFFE;
  localparam int unsigned WAIT_CNT_W   = 4;

endpackage

// File: rtl/sync_ram.sv
// Single-port word RAM: synchronous write, registered read, contents not reset.
module sync_ram #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata
);

  logic [15:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the SLC-3 memory port: word RAM plus switch/hex I/O.
// Optional MEM_ACCESS_CNT_EN adds an access counter readable/clearable at IO_ADDR-1.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [15:0] IO_ADDR     = IO_ADDR_DEF
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Mem_Req,
  input  logic        Mem_WE,
  input  logic [15:0] MAR,
  input  logic [15:0] MDR,
  input  logic [15:0] Switches,
  output logic [15:0] Data_To_CPU,
  output logic        Mem_Ready,
  output logic        Busy,
  output logic [15:0] HEX_Out
);

  localparam logic [15:0] CNT_ADDR = IO_ADDR - 16'd1;

  state_t                state, state_nx;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic [15:0]           req_addr, req_data, rd_hold, rd_val, ram_q;
  logic                  req_we, rd_ram;
  logic                  is_io, in_range, ram_en;

  assign is_io    = (req_addr == IO_ADDR);
  assign in_range = ((32'(req_addr) >> ADDR_W) == 32'd0) && !is_io;
  assign ram_en   = (state == ACCESS) && in_range;

`ifdef MEM_ACCESS_CNT_EN
  logic [15:0] acc_cnt;
  logic        is_cnt;
  assign is_cnt = (req_addr == CNT_ADDR);

  // Counts every access; a write to the counter address clears it instead.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      acc_cnt <= 16'h0000;
    end else if (state == ACCESS) begin
      if (req_we && is_cnt) acc_cnt <= 16'h0000;
      else                  acc_cnt <= acc_cnt + 16'd1;
    end
  end
`endif

  // Non-RAM read value captured during ACCESS.
  always_comb begin
    rd_val = 16'h0000;
    if (is_io) rd_val = Switches;
`ifdef MEM_ACCESS_CNT_EN
    else if (is_cnt) rd_val = acc_cnt;
`endif
  end

  sync_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (Clk),
    .en    (ram_en),
    .we    (req_we),
    .addr  (req_addr[ADDR_W-1:0]),
    .wdata (req_data),
    .rdata (ram_q)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (Mem_Req) state_nx = (WAIT_STATES == 0) ? ACCESS : WAIT;
      WAIT:    if (wait_cnt <= WAIT_CNT_W'(1)) state_nx = ACCESS;
      ACCESS:  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Request latch, wait counting and the registered outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wait_cnt    <= '0;
      req_addr    <= 16'h0000;
      req_data    <= 16'h0000;
      req_we      <= 1'b0;
      rd_hold     <= 16'h0000;
      rd_ram      <= 1'b0;
      Data_To_CPU <= 16'h0000;
      HEX_Out     <= 16'h0000;
      Mem_Ready   <= 1'b0;
      Busy        <= 1'b0;
    end else begin
      Mem_Ready <= (state == DONE);
      Busy      <= (state_nx != IDLE);
      case (state)
        IDLE: begin
          if (Mem_Req) begin
            req_addr <= MAR;
            req_data <= MDR;
            req_we   <= Mem_WE;
            wait_cnt <= WAIT_CNT_W'(WAIT_STATES);
          end
        end
        WAIT: wait_cnt <= wait_cnt - WAIT_CNT_W'(1);
        ACCESS: begin
          if (req_we) begin
            if (is_io) HEX_Out <= req_data;
          end else begin
            rd_ram  <= in_range;
            rd_hold <= rd_val;
          end
        end
        DONE: begin
          if (!req_we) Data_To_CPU <= rd_ram ? ram_q : rd_hold;
        end
        default: ;
      endcase
    end
  end

endmodule
